// File: rtl/sram_arbiter.sv
// sram_arbiter: CPU/GPU share one async 16-bit SRAM port; per-lane strobes and rdata masking when SRAM_ARB_BYTE_EN is defined.
// Latency: request seen in IDLE -> ack WAIT_CYCLES+2 clocks later; at least one IDLE clock separates accesses.
// Backpressure: requests are levels; a requester holds req until its one-cycle ack (GPU promoted after STARVE_LIMIT CPU wins).
module sram_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [1:0]  cpu_be,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        gpu_req,
    input  logic        gpu_we,
    input  logic [15:0] gpu_addr,
    input  logic [15:0] gpu_wdata,
    input  logic [1:0]  gpu_be,
    output logic        gpu_ack,
    output logic [15:0] gpu_rdata,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dout,
    output logic        sram_doe,
    input  logic [15:0] sram_din,
    output logic        busy,
    output logic        grant
);

    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam bit STARVE_EN = (STARVE_LIMIT != 0);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   cpu_rdata_q, cpu_rdata_d;
    logic [15:0]   gpu_rdata_q, gpu_rdata_d;

    logic          active;
    logic          gpu_win;
    logic          starve_full;
    logic [15:0]   lane_mask;

    assign active      = (state_q != S_IDLE);
    assign starve_full = STARVE_EN && (starve_q == STARVE_MAX);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cpu_rdata_d = cpu_rdata_q;
        gpu_rdata_d = gpu_rdata_q;
        gpu_win     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || gpu_req) begin
                    gpu_win = gpu_req && (!cpu_req || starve_full);
                    grant_d = gpu_win;
                    we_d    = gpu_win ? gpu_we    : cpu_we;
                    addr_d  = gpu_win ? gpu_addr  : cpu_addr;
                    wdata_d = gpu_win ? gpu_wdata : cpu_wdata;
                    be_d    = gpu_win ? gpu_be    : cpu_be;
                    state_d = S_SETUP;
                end
                // Counter only grows while the GPU is actually waiting behind a CPU win.
                if (gpu_win || !gpu_req) begin
                    starve_d = '0;
                end else if (cpu_req && starve_q != STARVE_MAX) begin
                    starve_d = starve_q + SW'(1);
                end
            end
            S_SETUP: begin
                wait_d  = WAIT_LAST;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (wait_q == '0) begin
                    state_d = S_HOLD;
                    if (!we_q) begin
                        if (grant_q) begin
                            gpu_rdata_d = sram_din & lane_mask;
                        end else begin
                            cpu_rdata_d = sram_din & lane_mask;
                        end
                    end
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_HOLD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            starve_q    <= '0;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            cpu_rdata_q <= '0;
            gpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cpu_rdata_q <= cpu_rdata_d;
            gpu_rdata_q <= gpu_rdata_d;
        end
    end

`ifdef SRAM_ARB_BYTE_EN
    assign lane_mask = {{8{be_q[1]}}, {8{be_q[0]}}};
    assign sram_ub_n = ~(active & be_q[1]);
    assign sram_lb_n = ~(active & be_q[0]);
`else
    logic unused_be;
    assign unused_be = ^be_q;
    assign lane_mask = 16'hFFFF;
    assign sram_ub_n = ~active;
    assign sram_lb_n = ~active;
`endif

    // OE stays low through HOLD on reads so data remains stable until CE releases.
    assign sram_ce_n = ~active;
    assign sram_oe_n = ~(active & ~we_q);
    assign sram_we_n = ~((state_q == S_STROBE) & we_q);
    assign sram_doe  = active & we_q;
    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;
    assign busy      = active;
    assign grant     = grant_q;
    assign cpu_ack   = (state_q == S_HOLD) & ~grant_q;
    assign gpu_ack   = (state_q == S_HOLD) & grant_q;
    assign cpu_rdata = cpu_rdata_q;
    assign gpu_rdata = gpu_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench: two arbiters (STARVE_LIMIT 4 and 0) share requester stimulus; each has its own pin-level SRAM and transaction model.
module tb_sram_arbiter;
    localparam int W  = 2;
    localparam int NI = 2;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, gpu_req, gpu_we;
    logic [15:0] cpu_addr, cpu_wdata, gpu_addr, gpu_wdata;
    logic [1:0]  cpu_be, gpu_be;

    logic        cpu_ack_w [NI];
    logic        gpu_ack_w [NI];
    logic [15:0] cpu_rdata_w [NI];
    logic [15:0] gpu_rdata_w [NI];
    logic        ce_n_w [NI];
    logic        oe_n_w [NI];
    logic        we_n_w [NI];
    logic        ub_n_w [NI];
    logic        lb_n_w [NI];
    logic [15:0] addr_w [NI];
    logic [15:0] dout_w [NI];
    logic        doe_w [NI];
    logic [15:0] din_w [NI];
    logic        busy_w [NI];
    logic        grant_w [NI];

    sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(4)) u_dut (
        .CLK(clk), .RST_N(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_ack(cpu_ack_w[0]), .cpu_rdata(cpu_rdata_w[0]),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata), .gpu_be(gpu_be),
        .gpu_ack(gpu_ack_w[0]), .gpu_rdata(gpu_rdata_w[0]),
        .sram_ce_n(ce_n_w[0]), .sram_oe_n(oe_n_w[0]), .sram_we_n(we_n_w[0]),
        .sram_ub_n(ub_n_w[0]), .sram_lb_n(lb_n_w[0]),
        .sram_addr(addr_w[0]), .sram_dout(dout_w[0]), .sram_doe(doe_w[0]), .sram_din(din_w[0]),
        .busy(busy_w[0]), .grant(grant_w[0])
    );

    sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(0)) u_dut_nolim (
        .CLK(clk), .RST_N(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_ack(cpu_ack_w[1]), .cpu_rdata(cpu_rdata_w[1]),
        .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata), .gpu_be(gpu_be),
        .gpu_ack(gpu_ack_w[1]), .gpu_rdata(gpu_rdata_w[1]),
        .sram_ce_n(ce_n_w[1]), .sram_oe_n(oe_n_w[1]), .sram_we_n(we_n_w[1]),
        .sram_ub_n(ub_n_w[1]), .sram_lb_n(lb_n_w[1]),
        .sram_addr(addr_w[1]), .sram_dout(dout_w[1]), .sram_doe(doe_w[1]), .sram_din(din_w[1]),
        .busy(busy_w[1]), .grant(grant_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction-level reference state, one set per DUT.
    int          free_at [NI];
    int          g_at [NI];
    bit          act [NI];
    int          starve [NI];
    logic        own [NI];
    logic        m_we [NI];
    logic [15:0] m_addr [NI];
    logic [15:0] m_wdata [NI];
    logic [1:0]  m_be [NI];
    logic [15:0] m_rd [NI];
    logic [15:0] exp_crd [NI];
    logic [15:0] exp_grd [NI];
    logic        exp_grant [NI];
    logic [15:0] pmem [NI][65536];
    logic [15:0] rmem [NI][65536];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic string tg(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    function automatic int lim(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic logic [15:0] lane_m(input logic [1:0] be);
`ifdef SRAM_ARB_BYTE_EN
        return {{8{be[1]}}, {8{be[0]}}};
`else
        return 16'hFFFF;
`endif
    endfunction

    task automatic model_edge(input int i);
        bit gw;
        if (!rst_n) begin
            act[i] = 0; free_at[i] = cyc + 1; starve[i] = 0;
            exp_grant[i] = 1'b0; exp_crd[i] = '0; exp_grd[i] = '0;
            return;
        end
        if (act[i] && cyc == g_at[i] + W + 1 && !m_we[i]) begin
            if (own[i]) exp_grd[i] = m_rd[i];
            else        exp_crd[i] = m_rd[i];
        end
        if (cyc >= free_at[i]) begin
            if (cpu_req || gpu_req) begin
                gw = gpu_req && (!cpu_req || (lim(i) != 0 && starve[i] == lim(i)));
                if (gw || !gpu_req) starve[i] = 0;
                else if (starve[i] < lim(i)) starve[i]++;
                own[i]     = gw;
                m_we[i]    = gw ? gpu_we    : cpu_we;
                m_addr[i]  = gw ? gpu_addr  : cpu_addr;
                m_wdata[i] = gw ? gpu_wdata : cpu_wdata;
                m_be[i]    = gw ? gpu_be    : cpu_be;
                if (m_we[i])
                    rmem[i][m_addr[i]] = (rmem[i][m_addr[i]] & ~lane_m(m_be[i])) | (m_wdata[i] & lane_m(m_be[i]));
                else
                    m_rd[i] = rmem[i][m_addr[i]] & lane_m(m_be[i]);
                exp_grant[i] = gw;
                g_at[i] = cyc; free_at[i] = cyc + W + 3; act[i] = 1;
            end else begin
                starve[i] = 0;
            end
        end
    endtask

    task automatic check_pins(input int i);
        int d;
        bit in_acc;
        d = cyc - g_at[i];
        in_acc = act[i] && d >= 0 && d <= W + 1;
        check_eq(tg("ce_n", i), 32'(ce_n_w[i]), 32'(!in_acc));
        check_eq(tg("busy", i), 32'(busy_w[i]), 32'(in_acc));
        check_eq(tg("we_n", i), 32'(we_n_w[i]), 32'(!(in_acc && m_we[i] && d >= 1 && d <= W)));
        check_eq(tg("doe", i), 32'(doe_w[i]), 32'(in_acc && m_we[i]));
        if (!in_acc || m_we[i]) check_eq(tg("oe_n_hi", i), 32'(oe_n_w[i]), 32'(1));
        else if (d <= W)        check_eq(tg("oe_n_lo", i), 32'(oe_n_w[i]), 32'(0));
`ifdef SRAM_ARB_BYTE_EN
        check_eq(tg("ub_n", i), 32'(ub_n_w[i]), 32'(!(in_acc && m_be[i][1])));
        check_eq(tg("lb_n", i), 32'(lb_n_w[i]), 32'(!(in_acc && m_be[i][0])));
`else
        check_eq(tg("ub_n", i), 32'(ub_n_w[i]), 32'(!in_acc));
        check_eq(tg("lb_n", i), 32'(lb_n_w[i]), 32'(!in_acc));
`endif
        check_eq(tg("cpu_ack", i), 32'(cpu_ack_w[i]), 32'(in_acc && d == W + 1 && !own[i]));
        check_eq(tg("gpu_ack", i), 32'(gpu_ack_w[i]), 32'(in_acc && d == W + 1 && own[i]));
        if (in_acc) check_eq(tg("addr", i), 32'(addr_w[i]), 32'(m_addr[i]));
        if (in_acc && m_we[i]) check_eq(tg("dout", i), 32'(dout_w[i]), 32'(m_wdata[i]));
        check_eq(tg("cpu_rdata", i), 32'(cpu_rdata_w[i]), 32'(exp_crd[i]));
        check_eq(tg("gpu_rdata", i), 32'(gpu_rdata_w[i]), 32'(exp_grd[i]));
        check_eq(tg("grant", i), 32'(grant_w[i]), 32'(exp_grant[i]));
    endtask

    task automatic pin_sram(input int i);
        logic [15:0] m;
        if (!ce_n_w[i] && !we_n_w[i]) begin
            m = {{8{!ub_n_w[i]}}, {8{!lb_n_w[i]}}};
            pmem[i][addr_w[i]] = (pmem[i][addr_w[i]] & ~m) | (dout_w[i] & m);
        end
        din_w[i] = pmem[i][addr_w[i]];
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) model_edge(i);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_pins(i);
            pin_sram(i);
        end
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int n = 0; n < 20 && !idle; n++) begin
            step();
            idle = !busy_w[0] && !busy_w[1];
        end
        check_eq("drain_timeout", 32'(idle), 32'(1));
    endtask

    // One access observed on the STARVE_LIMIT=4 instance; stats are counted over its busy window.
    task automatic do_access(input bit gpu, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, output int lat, output int we_lo, output int doe_hi,
                             output int oe_hi, output logic ub_s, output logic lb_s,
                             output logic [15:0] rd, output bit ack1);
        bit got;
        bit seen;
        lat = 0; we_lo = 0; doe_hi = 0; oe_hi = 0; ub_s = 1'b1; lb_s = 1'b1; rd = '0; ack1 = 0;
        got = 0; seen = 0;
        if (gpu) begin
            gpu_req = 1; gpu_we = we; gpu_addr = addr; gpu_wdata = wd; gpu_be = be;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            step();
            lat++;
            if (!we_n_w[0]) we_lo++;
            if (doe_w[0])   doe_hi++;
            if (oe_n_w[0])  oe_hi++;
            if (!seen && busy_w[0]) begin
                seen = 1; ub_s = ub_n_w[0]; lb_s = lb_n_w[0];
            end
            if (gpu ? gpu_ack_w[1] : cpu_ack_w[1]) ack1 = 1;
            got = gpu ? gpu_ack_w[0] : cpu_ack_w[0];
            rd  = gpu ? gpu_rdata_w[0] : cpu_rdata_w[0];
        end
        check_eq("ack_timeout", 32'(got), 32'(1));
        if (gpu) gpu_req = 0;
        else     cpu_req = 0;
        step();
    endtask

    task automatic rand_fields(input bit gpu);
        if (gpu) begin
            gpu_we = 1'($urandom_range(1, 0)); gpu_addr = 16'($urandom_range(15, 0));
            gpu_wdata = 16'($urandom); gpu_be = 2'($urandom_range(3, 0));
        end else begin
            cpu_we = 1'($urandom_range(1, 0)); cpu_addr = 16'($urandom_range(15, 0));
            cpu_wdata = 16'($urandom); cpu_be = 2'($urandom_range(3, 0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, we_lo, doe_hi, oe_hi, ng, nack;
        logic ub_s, lb_s;
        logic [15:0] rd;
        logic [9:0] seq;
        bit ack1, found, pb0, pb1;

        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 65536; a++) begin
                pmem[i][a] = '0;
                rmem[i][a] = '0;
            end
            free_at[i] = 0; g_at[i] = 0; act[i] = 0; starve[i] = 0; own[i] = 0;
            m_we[i] = 0; m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '0; m_rd[i] = '0;
            exp_crd[i] = '0; exp_grd[i] = '0; exp_grant[i] = 0; din_w[i] = '0;
        end
        rst_n = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 2'b11;
        gpu_req = 0; gpu_we = 0; gpu_addr = '0; gpu_wdata = '0; gpu_be = 2'b11;
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            check_eq(tg("rst_addr", i), 32'(addr_w[i]), 32'(0));
            check_eq(tg("rst_dout", i), 32'(dout_w[i]), 32'(0));
        end
        rst_n = 1;
        step();

        // Single CPU write: 4-cycle latency, WE low for WAIT_CYCLES, OE never low, DOE across whole access.
        do_access(0, 1, 16'h1234, 16'hBEEF, 2'b11, lat, we_lo, doe_hi, oe_hi, ub_s, lb_s, rd, ack1);
        check_eq("wr_latency", 32'(lat), 32'(4));
        check_eq("wr_we_low", 32'(we_lo), 32'(2));
        check_eq("wr_doe_high", 32'(doe_hi), 32'(4));
        check_eq("wr_oe_high", 32'(oe_hi), 32'(4));

        do_access(0, 0, 16'h1234, 16'h0000, 2'b11, lat, we_lo, doe_hi, oe_hi, ub_s, lb_s, rd, ack1);
        check_eq("rd_latency", 32'(lat), 32'(4));
        check_eq("rd_ack_data", 32'(rd), 32'(16'hBEEF));
        step();
        check_eq("rd_held", 32'(cpu_rdata_w[0]), 32'(16'hBEEF));

        // Continuous contention: limit 4 yields C,C,C,C,G,...; limit 0 never grants GPU.
        seq = 10'h210;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003; cpu_be = 2'b11;
        gpu_req = 1; gpu_we = 0; gpu_addr = 16'h0005; gpu_be = 2'b11;
        ng = 0; nack = 0; pb0 = 0; pb1 = 0;
        for (int n = 0; n < 200 && ng < 10; n++) begin
            step();
            if (busy_w[0] && !pb0) begin
                check_eq($sformatf("gseq%0d", ng), 32'(grant_w[0]), 32'(seq[ng]));
                ng++;
            end
            if (busy_w[1] && !pb1) check_eq("nolim_grant", 32'(grant_w[1]), 32'(0));
            nack += int'(cpu_ack_w[0]) + int'(gpu_ack_w[0]);
            pb0 = busy_w[0]; pb1 = busy_w[1];
        end
        check_eq("gseq_count", 32'(ng), 32'(10));
        check_eq("ack_count", 32'(nack), 32'(9));
        cpu_req = 0; gpu_req = 0;
        drain();

        // GPU alone is granted by both instances, including the pure fixed-priority one.
        do_access(1, 0, 16'h1234, 16'h0000, 2'b11, lat, we_lo, doe_hi, oe_hi, ub_s, lb_s, rd, ack1);
        check_eq("gpu_alone_lat", 32'(lat), 32'(4));
        check_eq("gpu_alone_nolim_ack", 32'(ack1), 32'(1));
        check_eq("gpu_alone_nolim_data", 32'(gpu_rdata_w[1]), 32'(16'hBEEF));

        // Reset in the middle of a write strobe.
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0077; cpu_wdata = 16'h1111; cpu_be = 2'b11;
        found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            step();
            found = !we_n_w[0];
        end
        check_eq("rst_reach_strobe", 32'(found), 32'(1));
        rst_n = 0; cpu_req = 0;
        step();
        check_eq("midrst_ce_n", 32'(ce_n_w[0]), 32'(1));
        check_eq("midrst_we_n", 32'(we_n_w[0]), 32'(1));
        check_eq("midrst_oe_n", 32'(oe_n_w[0]), 32'(1));
        check_eq("midrst_doe", 32'(doe_w[0]), 32'(0));
        check_eq("midrst_ack", 32'(cpu_ack_w[0]), 32'(0));
        rst_n = 1;
        do_access(1, 0, 16'h1234, 16'h0000, 2'b11, lat, we_lo, doe_hi, oe_hi, ub_s, lb_s, rd, ack1);
        check_eq("post_rst_lat", 32'(lat), 32'(4));
        check_eq("post_rst_data", 32'(rd), 32'(16'hBEEF));

        // Lane handling on a lower-byte read.
        for (int i = 0; i < NI; i++) begin
            pmem[i][16'h0040] = 16'hA55A;
            rmem[i][16'h0040] = 16'hA55A;
        end
        do_access(0, 0, 16'h0040, 16'h0000, 2'b01, lat, we_lo, doe_hi, oe_hi, ub_s, lb_s, rd, ack1);
`ifdef SRAM_ARB_BYTE_EN
        check_eq("be01_ub_n", 32'(ub_s), 32'(1));
        check_eq("be01_lb_n", 32'(lb_s), 32'(0));
        check_eq("be01_rdata", 32'(rd), 32'(16'h005A));
`else
        check_eq("be01_ub_n", 32'(ub_s), 32'(0));
        check_eq("be01_lb_n", 32'(lb_s), 32'(0));
        check_eq("be01_rdata", 32'(rd), 32'(16'hA55A));
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 1000; n++) begin
            step();
            if (cpu_req && cpu_ack_w[0]) begin
                if ($urandom_range(1, 0) == 0) cpu_req = 0;
                else rand_fields(0);
            end else if (!cpu_req && $urandom_range(3, 0) == 0) begin
                rand_fields(0);
                cpu_req = 1;
            end
            if (gpu_req && gpu_ack_w[0]) begin
                if ($urandom_range(1, 0) == 0) gpu_req = 0;
                else rand_fields(1);
            end else if (!gpu_req && $urandom_range(3, 0) == 0) begin
                rand_fields(1);
                gpu_req = 1;
            end
        end
        cpu_req = 0; gpu_req = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
